// File: rtl/simd_fetch_unit_if.sv
// Fetch-unit bus: kernel launch, instruction-memory read port, decoder handshake and status.
interface simd_fetch_unit_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] start_pc;
  logic                  imem_req;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic                  imem_rvalid;
  logic [31:0]           imem_rdata;
  logic [31:0]           instruction;
  logic                  instr_valid;
  logic                  instr_ready;
  logic [2:0]            type_instruction;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  busy;
  logic                  done;
  logic                  fetch_error;

  modport master (
    input  start, start_pc, imem_rvalid, imem_rdata, instr_ready, type_instruction,
    output imem_req, imem_addr, instruction, instr_valid, pc, busy, done, fetch_error
  );

  modport slave (
    output start, start_pc, imem_rvalid, imem_rdata, instr_ready, type_instruction,
    input  imem_req, imem_addr, instruction, instr_valid, pc, busy, done, fetch_error
  );
endinterface

// File: rtl/simd_fetch_unit.sv
// SIMD instruction fetch: REQ/WAIT/ISSUE loop until the return instruction is accepted.
// Optional memory-response watchdog enabled by defining SIMD_FETCH_WATCHDOG_EN.
module simd_fetch_unit #(
  parameter int ADDR_WIDTH      = 8,
  parameter int WATCHDOG_CYCLES = 64
) (
  input  logic               clk,
  input  logic               reset,
  simd_fetch_unit_if.master  bus
);

  // state   | meaning
  // S_IDLE  | waiting for start
  // S_REQ   | one-cycle read request at pc
  // S_WAIT  | waiting for imem_rvalid
  // S_ISSUE | instruction presented to decoder
  // S_DONE  | one-cycle done pulse
  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_ISSUE,
    S_DONE
  } state_t;

  localparam logic [2:0] TYPE_RET = 3'b111;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] pc_d;
  logic [31:0]           instr_q;
  logic                  imem_req_q;
  logic                  instr_valid_q;
  logic                  busy_q;
  logic                  done_q;

`ifdef SIMD_FETCH_WATCHDOG_EN
  localparam int WDW = $clog2(WATCHDOG_CYCLES + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(WATCHDOG_CYCLES - 1);
  logic [WDW-1:0] wd_cnt_q;
  logic           fetch_error_q;
`endif

  assign pc_d = pc_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      pc_q          <= '0;
      instr_q       <= '0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
`ifdef SIMD_FETCH_WATCHDOG_EN
      wd_cnt_q      <= '0;
      fetch_error_q <= 1'b0;
`endif
    end else begin
      imem_req_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            pc_q       <= bus.start_pc;
            state_q    <= S_REQ;
            imem_req_q <= 1'b1;
            busy_q     <= 1'b1;
`ifdef SIMD_FETCH_WATCHDOG_EN
            fetch_error_q <= 1'b0;
`endif
          end
        end
        S_REQ: begin
          state_q <= S_WAIT;
`ifdef SIMD_FETCH_WATCHDOG_EN
          wd_cnt_q <= '0;
`endif
        end
        S_WAIT: begin
          // A response on the timeout cycle takes priority over the watchdog.
          if (bus.imem_rvalid) begin
            instr_q       <= bus.imem_rdata;
            instr_valid_q <= 1'b1;
            state_q       <= S_ISSUE;
          end
`ifdef SIMD_FETCH_WATCHDOG_EN
          else if (wd_cnt_q == WD_LAST) begin
            fetch_error_q <= 1'b1;
            done_q        <= 1'b1;
            state_q       <= S_DONE;
          end else begin
            wd_cnt_q <= wd_cnt_q + 1'b1;
          end
`endif
        end
        S_ISSUE: begin
          if (bus.instr_ready) begin
            instr_valid_q <= 1'b0;
            if (bus.type_instruction == TYPE_RET) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              pc_q       <= pc_d;
              imem_req_q <= 1'b1;
              state_q    <= S_REQ;
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q       <= S_IDLE;
          imem_req_q    <= 1'b0;
          instr_valid_q <= 1'b0;
          busy_q        <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req    = imem_req_q;
  assign bus.imem_addr   = pc_q;
  assign bus.pc          = pc_q;
  assign bus.instruction = instr_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

`ifdef SIMD_FETCH_WATCHDOG_EN
  assign bus.fetch_error = fetch_error_q;
`else
  assign bus.fetch_error = 1'b0;
`endif

endmodule

// File: tb/tb_simd_fetch_unit.sv
// Directed bench for simd_fetch_unit: memory responder, scoreboard of issued words, step checks.
module tb_simd_fetch_unit;

  localparam logic [31:0] W_ADD = 32'h8B020020;
  localparam logic [31:0] W_SUB = 32'hCB020020;
  localparam logic [31:0] W_RET = 32'hD65F03C0;

  logic clk = 1'b0;
  logic reset;

  simd_fetch_unit_if #(.ADDR_WIDTH(8)) bus ();

  simd_fetch_unit #(.ADDR_WIDTH(8), .WATCHDOG_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Decoder stand-in: only the return word is type 111.
  assign bus.type_instruction = (bus.instruction == W_RET) ? 3'b111 : 3'b000;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  logic [31:0] mem [256];
  logic [31:0] sb_q [$];
  logic        mem_respond = 1'b1;
  int          resp_delay  = 0;
  logic        pend        = 1'b0;
  int          pend_cnt    = 0;
  logic [7:0]  pend_addr   = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int max);
    int n;
    n = 0;
    while (bus.done !== 1'b1 && n < max) begin
      tick();
      n++;
    end
    chkb("done_pulse", bus.done, 1'b1);
  endtask

  // Instruction memory: answers each request resp_delay cycles after the cycle following it.
  always @(posedge clk) begin
    #1;
    bus.imem_rvalid = 1'b0;
    if (pend) begin
      if (pend_cnt == 0) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = mem[pend_addr];
        sb_q.push_back(mem[pend_addr]);
        pend = 1'b0;
      end else begin
        pend_cnt = pend_cnt - 1;
      end
    end
    if (bus.imem_req === 1'b1 && mem_respond) begin
      pend      = 1'b1;
      pend_cnt  = resp_delay;
      pend_addr = bus.imem_addr;
    end
  end

  // Every accepted instruction must be the next word the memory returned.
  always @(negedge clk) begin
    if (bus.instr_valid === 1'b1 && bus.instr_ready === 1'b1) begin
      chk("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) chk("sb_instruction", bus.instruction, sb_q.pop_front());
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = W_ADD;
    mem[8'h10] = W_ADD;  mem[8'h11] = W_RET;
    mem[8'h20] = W_ADD;  mem[8'h21] = W_RET;
    mem[8'hFF] = W_SUB;  mem[8'h00] = W_RET;
    mem[8'h40] = W_RET;
    mem[8'h50] = W_RET;
    reset           = 1'b1;
    bus.start       = 1'b0;
    bus.start_pc    = 8'h00;
    bus.instr_ready = 1'b1;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    tick();
    tick();
    chkb("rst_busy", bus.busy, 1'b0);
    chkb("rst_req", bus.imem_req, 1'b0);
    chkb("rst_valid", bus.instr_valid, 1'b0);
    chkb("rst_done", bus.done, 1'b0);
    chkb("rst_ferr", bus.fetch_error, 1'b0);
    chk("rst_pc", 32'(bus.pc), 32'h0);
    chk("rst_instr", bus.instruction, 32'h0);
    reset = 1'b0;
    tick();

    // 1: two-instruction kernel, single-cycle memory, ready high
    bus.start = 1'b1; bus.start_pc = 8'h10;
    tick();
    bus.start = 1'b0;
    chkb("t1_req0", bus.imem_req, 1'b1);
    chk("t1_addr0", 32'(bus.imem_addr), 32'h10);
    chkb("t1_busy", bus.busy, 1'b1);
    tick();
    chkb("t1_req_drop", bus.imem_req, 1'b0);
    tick();
    chkb("t1_valid0", bus.instr_valid, 1'b1);
    chk("t1_instr0", bus.instruction, W_ADD);
    tick();
    chkb("t1_valid_drop", bus.instr_valid, 1'b0);
    chkb("t1_req1", bus.imem_req, 1'b1);
    chk("t1_addr1", 32'(bus.imem_addr), 32'h11);
    tick();
    tick();
    chk("t1_instr1", bus.instruction, W_RET);
    tick();
    chkb("t1_done", bus.done, 1'b1);
    chkb("t1_done_busy", bus.busy, 1'b1);
    chkb("t1_done_valid", bus.instr_valid, 1'b0);
    chk("t1_pc", 32'(bus.pc), 32'h11);
    tick();
    chkb("t1_done_once", bus.done, 1'b0);
    chkb("t1_busy_fall", bus.busy, 1'b0);
    chkb("t1_ferr", bus.fetch_error, 1'b0);

    // 2: backpressure for 5 cycles on an ADD
    bus.instr_ready = 1'b0;
    bus.start = 1'b1; bus.start_pc = 8'h20;
    tick();
    bus.start = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      chkb("t2_hold_valid", bus.instr_valid, 1'b1);
      chk("t2_hold_instr", bus.instruction, W_ADD);
      chkb("t2_no_req", bus.imem_req, 1'b0);
      chk("t2_hold_pc", 32'(bus.pc), 32'h20);
    end
    bus.instr_ready = 1'b1;
    tick();
    chkb("t2_req_after", bus.imem_req, 1'b1);
    chk("t2_pc_after", 32'(bus.pc), 32'h21);
    wait_done(20);
    tick();

    // 3: pc wraps from 0xFF to 0x00
    bus.start = 1'b1; bus.start_pc = 8'hFF;
    tick();
    bus.start = 1'b0;
    chk("t3_addr0", 32'(bus.imem_addr), 32'hFF);
    tick();
    tick();
    chk("t3_instr0", bus.instruction, W_SUB);
    tick();
    chkb("t3_req1", bus.imem_req, 1'b1);
    chk("t3_addr_wrap", 32'(bus.imem_addr), 32'h00);
    wait_done(20);
    chk("t3_pc_end", 32'(bus.pc), 32'h00);
    tick();

    // 4: reset while in WAIT, response arrives after reset
    resp_delay = 1;
    bus.start = 1'b1; bus.start_pc = 8'h10;
    tick();
    bus.start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chkb("t4_busy", bus.busy, 1'b0);
    chkb("t4_valid", bus.instr_valid, 1'b0);
    chkb("t4_req", bus.imem_req, 1'b0);
    chkb("t4_done", bus.done, 1'b0);
    chk("t4_instr", bus.instruction, 32'h0);
    chk("t4_pc", 32'(bus.pc), 32'h0);
    tick();
    chkb("t4_still_idle", bus.busy, 1'b0);
    chk("t4_word_unused", 32'(sb_q.size()), 32'd1);
    sb_q.delete();
    resp_delay = 0;

    // 5: start in ISSUE and in DONE is ignored
    bus.instr_ready = 1'b0;
    bus.start = 1'b1; bus.start_pc = 8'h40;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    bus.start = 1'b1; bus.start_pc = 8'h55;
    tick();
    chk("t5_pc_issue", 32'(bus.pc), 32'h40);
    chkb("t5_valid_issue", bus.instr_valid, 1'b1);
    bus.start = 1'b0;
    bus.instr_ready = 1'b1;
    tick();
    chkb("t5_done", bus.done, 1'b1);
    bus.start = 1'b1; bus.start_pc = 8'h66;
    tick();
    bus.start = 1'b0;
    chkb("t5_idle_busy", bus.busy, 1'b0);
    chkb("t5_idle_req", bus.imem_req, 1'b0);
    chk("t5_pc_kept", 32'(bus.pc), 32'h40);
    tick();
    chkb("t5_no_launch", bus.imem_req, 1'b0);

`ifdef SIMD_FETCH_WATCHDOG_EN
    // 6: memory never answers -> timeout after the 4th WAIT cycle
    mem_respond = 1'b0;
    bus.start = 1'b1; bus.start_pc = 8'h50;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    tick();
    chkb("t6_no_done_yet", bus.done, 1'b0);
    chkb("t6_no_err_yet", bus.fetch_error, 1'b0);
    tick();
    chkb("t6_done", bus.done, 1'b1);
    chkb("t6_err", bus.fetch_error, 1'b1);
    tick();
    chkb("t6_busy_fall", bus.busy, 1'b0);
    chkb("t6_err_hold", bus.fetch_error, 1'b1);
    // Repeat with the answer on the 4th WAIT cycle
    mem_respond = 1'b1;
    resp_delay  = 3;
    bus.start = 1'b1; bus.start_pc = 8'h50;
    tick();
    bus.start = 1'b0;
    chkb("t6_err_cleared", bus.fetch_error, 1'b0);
    tick();
    tick();
    tick();
    tick();
    chkb("t6_waiting", bus.instr_valid, 1'b0);
    tick();
    chkb("t6_late_valid", bus.instr_valid, 1'b1);
    chk("t6_late_instr", bus.instruction, W_RET);
    chkb("t6_late_no_err", bus.fetch_error, 1'b0);
    wait_done(10);
    chkb("t6_end_no_err", bus.fetch_error, 1'b0);
    tick();
    resp_delay = 0;
`endif

    tick();
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    chkb("end_ferr", bus.fetch_error, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/simd_fetch_unit.md
Name: simd_fetch_unit

Overview:
- Instruction fetch stage directly upstream of the SIMD decoder.
- Walks a kernel's instruction stream from a start address, one word per instruction.
- Presents each 32-bit instruction to the decoder with a valid/ready handshake.
- Watches the decoder's type_instruction feedback and stops after the return instruction (type 3'b111) is consumed; then pulses done.

Parameters:
- ADDR_WIDTH, 8: instruction memory word-address width; the PC wraps modulo 2^ADDR_WIDTH.
- WATCHDOG_CYCLES, 64: maximum wait for a memory response. Used only with SIMD_FETCH_WATCHDOG_EN.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  launch kernel fetch; sampled only in IDLE.
- start_pc  input  ADDR_WIDTH  first instruction address; sampled together with start.
- imem_req  output  1  one-cycle read request to instruction memory.
- imem_addr  output  ADDR_WIDTH  read address; equals pc.
- imem_rvalid  input  1  read data valid; earliest the cycle after imem_req.
- imem_rdata  input  32  read data.
- instruction  output  32  instruction register, driven to the decoder.
- instr_valid  output  1  instruction holds a valid word.
- instr_ready  input  1  downstream accepts instruction.
- type_instruction  input  3  decoder classification of the current instruction (combinational from instruction).
- pc  output  ADDR_WIDTH  current fetch address.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse after the return instruction is accepted.
- fetch_error  output  1  watchdog timeout flag (feature only; tied 0 otherwise).

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; pc=0; instruction=0.
  - imem_req, instr_valid, busy, done, fetch_error = 0.
  - Reset mid-operation abandons the kernel; a later imem_rvalid is ignored.
- State IDLE:
  - start=1 loads pc<=start_pc and moves to REQ.
  - start outside IDLE is ignored.
- State REQ:
  - imem_req=1 for exactly one cycle, with imem_addr=pc.
  - Always moves to WAIT.
- State WAIT:
  - imem_req=0.
  - On imem_rvalid: instruction<=imem_rdata, move to ISSUE.
  - imem_rvalid in any other state is ignored.
- State ISSUE:
  - instr_valid=1.
  - instruction and pc stay stable until the handshake (instr_valid && instr_ready).
  - On handshake with type_instruction==3'b111: move to DONE; pc is not incremented.
  - On handshake with any other type: pc<=pc+1 (wraps from 2^ADDR_WIDTH-1 to 0), move to REQ.
- State DONE:
  - done=1 for one cycle; instr_valid=0.
  - Moves to IDLE.
  - A start in the DONE cycle is ignored.
- Latency:
  - start at cycle t gives imem_req at t+1.
  - rvalid at cycle r gives instr_valid at r+1.
  - Handshake at cycle h gives the next imem_req at h+1, or done at h+1 for a return.
  - Minimum of 3 cycles per instruction (REQ, WAIT, ISSUE) with single-cycle memory and ready held high.
- busy is high in REQ, WAIT, ISSUE and DONE.
- No instruction is ever dropped or duplicated; each fetched word is issued exactly once.

Optional Feature:
- Macro: SIMD_FETCH_WATCHDOG_EN.
- With the macro defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle without imem_rvalid.
  - If the counter reaches WATCHDOG_CYCLES, fetch_error<=1 and the unit moves to DONE (done pulses).
  - fetch_error holds until the next accepted start or reset.
  - rvalid arriving on the timeout cycle wins: data is captured and there is no error.
- Without the macro:
  - No counter is built.
  - fetch_error is constant 0.
  - WAIT waits indefinitely.

Test Plan:
1. Reset; start=1, start_pc=0x10; memory returns 0x8B020020 (ADD, type 000) then 0xD65F03C0 (type 111), with rvalid one cycle after each req and ready held high -> imem_addr 0x10 then 0x11; instruction shows each word for one cycle; done pulses once; busy falls the cycle after done; pc=0x11.
2. Backpressure: instr_ready low for 5 cycles while an ADD is issued -> instr_valid and instruction=0x8B020020 hold; no new imem_req; pc unchanged until ready rises.
3. Wrap: start_pc=0xFF, first word SUB 0xCB020020 -> second request has imem_addr=0x00.
4. Reset asserted in WAIT, then rvalid pulses the next cycle -> all outputs stay 0; state stays IDLE; instruction stays 0.
5. start pulsed while in ISSUE and in the DONE cycle -> ignored; pc is not reloaded.
6. SIMD_FETCH_WATCHDOG_EN, WATCHDOG_CYCLES=4, memory never responds -> fetch_error=1 and done pulses 4 cycles after entering WAIT. A repeat run with rvalid on the 4th WAIT cycle -> instruction is issued and fetch_error=0.
